// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle control FSM (master) and the
// RV32I datapath (slave): instruction fields and ALU flag in, selects and
// write enables out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       branch_cond;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       instr_done;
  logic       illegal_instr;

  modport master (
    input  op, funct3, funct7b5, branch_cond,
    output ALUControl, ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, AdrSrc,
           IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_instr
  );

  modport slave (
    output op, funct3, funct7b5, branch_cond,
    input  ALUControl, ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, AdrSrc,
           IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_instr
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I datapath.
//
// state    | meaning
// FETCH    | read instruction at PC, latch IR/OldPC, PC <= PC+4
// DECODE   | read registers, precompute OldPC+imm, reject unsupported ops
// MEMADR   | rs1 + imm for lw/sw
// MEMREAD  | read data memory at computed address
// MEMWB    | write loaded word to rd (last cycle of lw)
// MEMWRITE | write rs2 to data memory (last cycle of sw)
// EXECR    | ALU on rs1, rs2
// EXECI    | ALU on rs1, immediate
// ALUWB    | write ALUOut to rd (last cycle of R/I/jal)
// JAL      | PC <= jump target, ALU computes return address OldPC+4
// BRANCH   | compare rs1/rs2, PC <= target when branch_cond
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input logic               clk,
  input logic               reset,
  multicycle_controller_if.master ctrl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  state_t state_q, state_d;

  logic is_lw, is_sw, is_r, is_i, is_br, is_jal;
  logic alu_f3_ok, br_f3_ok, legal;
  logic [2:0] alu_funct;

  assign is_lw  = (ctrl.op == 7'b0000011);
  assign is_sw  = (ctrl.op == 7'b0100011);
  assign is_r   = (ctrl.op == 7'b0110011);
  assign is_i   = (ctrl.op == 7'b0010011);
  assign is_br  = (ctrl.op == 7'b1100011);
  assign is_jal = (ctrl.op == 7'b1101111);

  // Legal funct3: ALU ops exclude 001/101; branches accept 000/001/100/101.
  assign alu_f3_ok = (ctrl.funct3 != 3'b001) && (ctrl.funct3 != 3'b101);
  assign br_f3_ok  = (ctrl.funct3 == 3'b000) || (ctrl.funct3 == 3'b001) ||
                     (ctrl.funct3 == 3'b100) || (ctrl.funct3 == 3'b101);
  assign legal = is_lw || is_sw || is_jal || (is_br && br_f3_ok) ||
                 ((is_r || is_i) && alu_f3_ok);

  // ALU operation for EXECR/EXECI; op[5] separates R-type so addi never becomes sub.
  always_comb begin
    alu_funct = 3'b000;
    case (ctrl.funct3)
      3'b000:  alu_funct = (ctrl.op[5] && ctrl.funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_funct = 3'b100;
      3'b011:  alu_funct = 3'b110;
      3'b100:  alu_funct = 3'b101;
      3'b110:  alu_funct = 3'b011;
      3'b111:  alu_funct = 3'b010;
      default: alu_funct = 3'b000;
    endcase
  end

  // Next-state selection; unreachable encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!legal)               state_d = S_FETCH;
        else if (is_lw || is_sw)  state_d = S_MEMADR;
        else if (is_r)            state_d = S_EXECR;
        else if (is_i)            state_d = S_EXECI;
        else if (is_br)           state_d = S_BRANCH;
        else                      state_d = S_JAL;
      end
      S_MEMADR:  state_d = ctrl.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) state_q <= state_t'(RESET_STATE);
    else       state_q <= state_d;
  end

  // Moore output decode; reset shows FETCH selects with every enable held low.
  always_comb begin
    ctrl.ALUControl    = 3'b000;
    ctrl.ALUSrcA       = 2'b00;
    ctrl.ALUSrcB       = 2'b00;
    ctrl.ImmSrc        = 3'b000;
    ctrl.ResultSrc     = 2'b00;
    ctrl.AdrSrc        = 1'b0;
    ctrl.IRWrite       = 1'b0;
    ctrl.PCWrite       = 1'b0;
    ctrl.RegWrite      = 1'b0;
    ctrl.MemWrite      = 1'b0;
    ctrl.instr_done    = 1'b0;
    ctrl.illegal_instr = 1'b0;
    if (reset) begin
      ctrl.ALUSrcB   = 2'b10;
      ctrl.ResultSrc = 2'b10;
    end else begin
      case (state_q)
        S_FETCH: begin
          ctrl.IRWrite   = 1'b1;
          ctrl.ALUSrcB   = 2'b10;
          ctrl.ResultSrc = 2'b10;
          ctrl.PCWrite   = 1'b1;
        end
        S_DECODE: begin
          ctrl.ALUSrcA       = 2'b01;
          ctrl.ALUSrcB       = 2'b01;
          ctrl.ImmSrc        = is_sw ? 3'b001 : is_br ? 3'b010 :
                               is_jal ? 3'b011 : 3'b000;
          ctrl.illegal_instr = !legal;
        end
        S_MEMADR: begin
          ctrl.ALUSrcA = 2'b10;
          ctrl.ALUSrcB = 2'b01;
          ctrl.ImmSrc  = ctrl.op[5] ? 3'b001 : 3'b000;
        end
        S_MEMREAD: ctrl.AdrSrc = 1'b1;
        S_MEMWB: begin
          ctrl.ResultSrc  = 2'b01;
          ctrl.RegWrite   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          ctrl.AdrSrc     = 1'b1;
          ctrl.MemWrite   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_EXECR: begin
          ctrl.ALUSrcA    = 2'b10;
          ctrl.ALUControl = alu_funct;
        end
        S_EXECI: begin
          ctrl.ALUSrcA    = 2'b10;
          ctrl.ALUSrcB    = 2'b01;
          ctrl.ALUControl = alu_funct;
        end
        S_ALUWB: begin
          ctrl.RegWrite   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_JAL: begin
          ctrl.ALUSrcA = 2'b01;
          ctrl.ALUSrcB = 2'b10;
          ctrl.PCWrite = 1'b1;
        end
        S_BRANCH: begin
          ctrl.ALUSrcA    = 2'b10;
          ctrl.ALUControl = 3'b001;
          ctrl.ImmSrc     = 3'b010;
          ctrl.PCWrite    = ctrl.branch_cond;
          ctrl.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instructions plus random ones,
// compared cycle by cycle against a per-instruction-class output table.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails = 0;

  multicycle_controller_if bus();
  multicycle_controller #(.RESET_STATE(4'd0)) dut (.clk(clk), .reset(reset), .ctrl(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] imm;
    logic [1:0] res;
    logic       adr, irw, pcw, rw, mw, done, ill;
  } outs_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

  function automatic int kind_of(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return (f3 == 3'd1 || f3 == 3'd5) ? K_ILL : K_R;
      7'b0010011: return (f3 == 3'd1 || f3 == 3'd5) ? K_ILL : K_I;
      7'b1100011: return (f3 inside {3'd0, 3'd1, 3'd4, 3'd5}) ? K_BR : K_ILL;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic int ncyc(input int k);
    case (k)
      K_LW:    return 5;
      K_BR:    return 3;
      K_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input int k, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (k == K_R && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b100;
      3'd3:    return 3'b110;
      3'd4:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs and the mask of specified fields for cycle c of one instruction.
  function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic bc, input int c, output outs_t e, output outs_t m);
    int k = kind_of(op, f3);
    e = '0; m = '0;
    m.irw = 1; m.pcw = 1; m.rw = 1; m.mw = 1; m.done = 1; m.ill = 1;
    if (c == 0) begin
      e.irw = 1; e.srcb = 2'b10; e.res = 2'b10; e.pcw = 1;
      m.adr = 1; m.srca = '1; m.srcb = '1; m.alu = '1; m.res = '1;
    end else if (c == 1) begin
      e.srca = 2'b01; e.srcb = 2'b01; e.ill = (k == K_ILL);
      m.srca = '1; m.srcb = '1; m.alu = '1;
      if (k != K_ILL && k != K_R) begin
        m.imm = '1;
        e.imm = (k == K_SW) ? 3'b001 : (k == K_BR) ? 3'b010 : (k == K_JAL) ? 3'b011 : 3'b000;
      end
    end else begin
      case (k)
        K_LW, K_SW: begin
          if (c == 2) begin
            e.srca = 2'b10; e.srcb = 2'b01; e.imm = (k == K_SW) ? 3'b001 : 3'b000;
            m.srca = '1; m.srcb = '1; m.alu = '1; m.imm = '1;
          end else if (c == 3 && k == K_LW) begin
            e.adr = 1; m.adr = 1; m.res = '1;
          end else if (c == 3) begin
            e.adr = 1; e.mw = 1; e.done = 1; m.adr = 1; m.res = '1;
          end else begin
            e.res = 2'b01; e.rw = 1; e.done = 1; m.res = '1;
          end
        end
        K_R, K_I, K_JAL: begin
          if (c == 2 && k == K_JAL) begin
            e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1;
            m.srca = '1; m.srcb = '1; m.alu = '1; m.res = '1;
          end else if (c == 2) begin
            e.srca = 2'b10; e.srcb = (k == K_I) ? 2'b01 : 2'b00; e.alu = alu_of(k, f3, f7);
            m.srca = '1; m.srcb = '1; m.alu = '1;
            if (k == K_I) m.imm = '1;
          end else begin
            e.rw = 1; e.done = 1; m.res = '1;
          end
        end
        K_BR: begin
          e.srca = 2'b10; e.alu = 3'b001; e.imm = 3'b010; e.pcw = bc; e.done = 1;
          m.srca = '1; m.srcb = '1; m.alu = '1; m.res = '1; m.imm = '1;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o.alu = bus.ALUControl; o.srca = bus.ALUSrcA; o.srcb = bus.ALUSrcB; o.imm = bus.ImmSrc;
    o.res = bus.ResultSrc; o.adr = bus.AdrSrc; o.irw = bus.IRWrite; o.pcw = bus.PCWrite;
    o.rw = bus.RegWrite; o.mw = bus.MemWrite; o.done = bus.instr_done; o.ill = bus.illegal_instr;
    return o;
  endfunction

  task automatic check(input string tag, input outs_t obs, input outs_t exp_v, input outs_t msk);
    logic [18:0] o, x, mk;
    o = obs; x = exp_v; mk = msk;
    checks++;
    assert ((o & mk) === (x & mk)) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b mask=%b", tag, o, x, mk);
    end
  endtask

  task automatic check_reset(input string tag);
    outs_t e, m;
    model(7'b0, 3'b0, 1'b0, 1'b0, 0, e, m);
    e.irw = 0; e.pcw = 0;
    check(tag, observed(), e, m);
  endtask

  // Runs one instruction from FETCH; limit > 0 stops early (used to cut in with reset).
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic bc, input int limit);
    int k = kind_of(op, f3);
    int n = ncyc(k);
    outs_t e, m;
    if (limit > 0 && limit < n) n = limit;
    for (int c = 0; c < n; c++) begin
      bus.op          = (c == 0) ? 7'($urandom) : op;
      bus.funct3      = (c == 0) ? 3'($urandom) : f3;
      bus.funct7b5    = (c == 0) ? 1'($urandom) : f7;
      bus.branch_cond = (k == K_BR && c == 2) ? bc : 1'($urandom);
      @(negedge clk);
      model(op, f3, f7, bc, c, e, m);
      check($sformatf("op=%b f3=%b f7=%b bc=%b cyc%0d", op, f3, f7, bc, c), observed(), e, m);
      @(posedge clk); #1;
    end
  endtask

  logic [6:0] rop;
  logic [2:0] rf3;

  initial begin
    bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 0; bus.branch_cond = 0;
    reset = 1;
    repeat (3) begin @(negedge clk); check_reset("reset_init"); end
    @(posedge clk); #1 reset = 0;

    // sw interrupted by reset in MEMWRITE
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3);
    reset = 1;
    repeat (3) begin @(negedge clk); check_reset("reset_in_memwrite"); @(posedge clk); #1; end
    reset = 0;

    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0);   // lw
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0);   // sw
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0);   // sub
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0);   // add
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0);   // addi, funct7b5=1
    run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 0);   // slt
    run_instr(7'b0110011, 3'b011, 1'b0, 1'b0, 0);   // sltu
    run_instr(7'b0110011, 3'b100, 1'b0, 1'b0, 0);   // xor
    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 0);   // or
    run_instr(7'b0010011, 3'b111, 1'b0, 1'b0, 0);   // andi
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0);   // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0);   // beq not taken
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0);   // jal
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0);   // unknown op
    run_instr(7'b1100011, 3'b010, 1'b0, 1'b1, 0);   // branch, bad funct3
    run_instr(7'b0010011, 3'b001, 1'b0, 1'b0, 0);   // slli
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0);   // lw after illegals

    for (int i = 0; i < 300; i++) begin
      rf3 = 3'($urandom);
      case ($urandom_range(0, 6))
        0: rop = 7'b0000011;
        1: rop = 7'b0100011;
        2: rop = 7'b0110011;
        3: rop = 7'b0010011;
        4: rop = 7'b1100011;
        5: rop = 7'b1101111;
        default: begin
          rop = 7'($urandom);
          if (rop inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111})
            rop = 7'b1111111;
        end
      endcase
      run_instr(rop, rf3, 1'($urandom), 1'($urandom), 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I datapath. It is the producing end of the ALU control interface.
- Decodes the instruction register fields and drives, cycle by cycle:
  - ALUControl, using the 3-bit encoding the ALU consumes;
  - operand and result muxes;
  - PC, IR, register-file and memory write enables.
- Consumes branch_cond returned by the ALU to resolve conditional branches.

Parameters:
- RESET_STATE, 4'd0: state encoding entered on reset (FETCH); fixed, exposed only for bench visibility.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- op  input  7  instruction bits [6:0] from IR
- funct3  input  3  instruction bits [14:12]
- funct7b5  input  1  instruction bit 30
- branch_cond  input  1  ALU branch comparison result
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor, 110 sltu
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 register
- ALUSrcB  output  2  00 rs2 register, 01 ImmExt, 10 constant 4
- ImmSrc  output  3  000 I, 001 S, 010 B, 011 J
- ResultSrc  output  2  00 ALUOut, 01 memory data, 10 ALU result direct
- AdrSrc  output  1  0 PC, 1 Result
- IRWrite  output  1  latch instruction and OldPC
- PCWrite  output  1  PC enable = PCUpdate | (Branch & branch_cond)
- RegWrite  output  1  register-file write enable
- MemWrite  output  1  data memory write enable
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction
- illegal_instr  output  1  one-cycle pulse in DECODE for an unsupported op/funct3

Behaviour:
- Moore FSM. All outputs are combinational from the state register plus op/funct3/funct7b5; there is no output latency beyond the state.
- Supported decode:
  - lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111.
  - Branch funct3 in {000, 001, 100, 101}.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE branches on op:
    - lw/sw -> MEMADR; R -> EXECR; I -> EXECI; branch -> BRANCH; jal -> JAL.
    - Anything else -> FETCH with illegal_instr=1.
  - MEMADR -> MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECR / EXECI -> ALUWB -> FETCH.
  - JAL -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Cycle counts: lw 5, sw 4, R 4, I 4, jal 4, branch 3. instr_done is high in MEMWB, MEMWRITE, ALUWB, BRANCH.
- Per-state outputs (all unlisted enables are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUControl=000 (branch/jump target precompute), ImmSrc per op.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUControl=000, ImmSrc=000 (lw) or 001 (sw).
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from funct decode.
  - EXECI: as EXECR but ALUSrcB=01, ImmSrc=000.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=00, PCWrite=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=001, ResultSrc=00, ImmSrc=010, PCWrite=branch_cond.
- funct decode for EXECR/EXECI, by funct3:
  - 000 -> sub (001) only if op[5]&funct7b5, else add (000); I-type addi is never sub.
  - 010 -> 100; 011 -> 110; 100 -> 101; 110 -> 011; 111 -> 010.
  - 001/101 (shifts, unsupported) -> 000 and illegal_instr in DECODE.
- Reset:
  - Synchronous. On a clk edge with reset=1, the state goes to FETCH regardless of current state, including mid-instruction.
  - While reset=1, PCWrite, IRWrite, RegWrite, MemWrite, instr_done and illegal_instr are forced 0.
  - Other outputs show FETCH values.
- branch_cond is sampled only in BRANCH and ignored in every other state. X on op outside DECODE/MEMADR/EXEC* must not affect outputs.
- Unreachable state encodings -> FETCH on the next edge, with all enables 0.

Test Plan:
- Reset held 3 cycles during MEMWRITE of sw -> MemWrite=0 while reset=1; first post-reset cycle is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10.
- lw (op=0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01; instr_done pulses once.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> EXECR ALUControl=001. addi with funct7b5=1 (op=0010011) -> ALUControl=000. slt/sltu/xor/or/and -> 100/110/101/011/010.
- beq with branch_cond=1 -> PCWrite=1 in cycle 3. Same with branch_cond=0 -> PCWrite=0; 3 cycles; RegWrite=0 throughout.
- jal (op=1101111) -> DECODE ImmSrc=011; JAL state PCWrite=1, ALUSrcA=01, ALUSrcB=10; ALUWB RegWrite=1.
- op=1111111, then a branch with funct3=010, then slli -> illegal_instr=1 in DECODE, next state FETCH, no write enable asserted.
